// File: rtl/value_display.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : font16x32 / value_display                                   |
// | Description : font16x32 renders one decimal glyph (seven-segment style)  |
// |               in a 16x32 cell. value_display converts a binary value to  |
// |               BCD with a sequential double-dabble engine, optionally     |
// |               defers the digit update to a frame boundary, and renders   |
// |               N right-aligned glyphs with leading-zero blanking.         |
// | Revision    : 1.0 - initial release                                      |
// +---------------------------------------------------------------------------+

module font16x32 #(
   parameter int X0 = 0,
   parameter int Y0 = 0
) (
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic [3:0] code,
   output logic       on_char
);

   // Offsets relative to the cell origin; pixels left of / above the cell
   // wrap to large unsigned values and fall outside the box test.
   logic [11:0] w_dx;
   logic [11:0] w_dy;
   logic        w_in_box;
   logic [3:0]  w_col;
   logic [4:0]  w_row;
   logic [6:0]  w_mask;   // {a,b,c,d,e,f,g}
   logic [6:0]  w_seg_hit;

   assign w_dx     = 12'(x) - 12'(X0);
   assign w_dy     = 12'(y) - 12'(Y0);
   assign w_in_box = (w_dx < 12'd16) && (w_dy < 12'd32);
   assign w_col    = w_dx[3:0];
   assign w_row    = w_dy[4:0];

   // Segment geometry inside the 16x32 cell, 4-pixel strokes.
   assign w_seg_hit[6] = (w_row <= 5'd3)  && (w_col >= 4'd2) && (w_col <= 4'd13);
   assign w_seg_hit[5] = (w_row >= 5'd2)  && (w_row <= 5'd15) && (w_col >= 4'd12);
   assign w_seg_hit[4] = (w_row >= 5'd16) && (w_row <= 5'd29) && (w_col >= 4'd12);
   assign w_seg_hit[3] = (w_row >= 5'd28) && (w_col >= 4'd2) && (w_col <= 4'd13);
   assign w_seg_hit[2] = (w_row >= 5'd16) && (w_row <= 5'd29) && (w_col <= 4'd3);
   assign w_seg_hit[1] = (w_row >= 5'd2)  && (w_row <= 5'd15) && (w_col <= 4'd3);
   assign w_seg_hit[0] = (w_row >= 5'd14) && (w_row <= 5'd17) && (w_col >= 4'd2) && (w_col <= 4'd13);

   // Character code to lit-segment set; codes above 9 render blank.
   always_comb begin
      w_mask = 7'b0000000;
      case (code)
         4'd0:    w_mask = 7'b1111110;
         4'd1:    w_mask = 7'b0110000;
         4'd2:    w_mask = 7'b1101101;
         4'd3:    w_mask = 7'b1111001;
         4'd4:    w_mask = 7'b0110011;
         4'd5:    w_mask = 7'b1011011;
         4'd6:    w_mask = 7'b1011111;
         4'd7:    w_mask = 7'b1110000;
         4'd8:    w_mask = 7'b1111111;
         4'd9:    w_mask = 7'b1111011;
         default: w_mask = 7'b0000000;
      endcase
   end

   assign on_char = w_in_box && (|(w_mask & w_seg_hit));

endmodule

module value_display #(
   parameter int DIGITS      = 3,
   parameter int VALUE_W     = 10,
   parameter int x1          = 0,
   parameter int y1          = 0,
   parameter int BLANK_LZ    = 1,
   parameter int SYNC_COMMIT = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [VALUE_W-1:0] value,
   input  logic               load,
   input  logic               frame_start,
   input  logic [9:0]         x,
   input  logic [9:0]         y,
   output logic               busy,
   output logic               overflow,
   output logic               on_display
);

   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int k = 0; k < n; k++) r = r * 10;
      return r;
   endfunction

   localparam int c_BCD_W = 4 * DIGITS;
   localparam int c_CNT_W = $clog2(VALUE_W + 1);
   localparam int c_CMP_W = (VALUE_W > 20) ? VALUE_W : 20;
   localparam logic [c_CMP_W-1:0] c_MAX  = c_CMP_W'(pow10(DIGITS) - 1);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(VALUE_W - 1);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_SHIFT  = 2'd1;
   localparam logic [1:0] c_WAIT   = 2'd2;
   localparam logic [1:0] c_COMMIT = 2'd3;

   logic [1:0]                 r_state;
   logic [VALUE_W-1:0]         r_bin;
   logic [c_BCD_W-1:0]         r_bcd;
   logic [c_CNT_W-1:0]         r_cnt;
   logic                       r_ovf_pend;
   logic [c_BCD_W-1:0]         r_digits;
   logic                       r_overflow;
   logic                       r_on;

   logic [c_BCD_W-1:0]         w_bcd_adj;
   logic [c_BCD_W+VALUE_W-1:0] w_shifted;
   logic [DIGITS-1:0]          w_nz;
   logic [DIGITS-1:0]          w_show;
   logic [DIGITS-1:0]          w_on_char;

   // Add-3 correction on every nibble that would exceed 9 after doubling.
   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      assign w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ?
                                   (r_bcd[4*i +: 4] + 4'd3) : r_bcd[4*i +: 4];
   end

   // One double-dabble step: shift the combined {bcd, bin} register left.
   assign w_shifted = {w_bcd_adj, r_bin} << 1;

   // Conversion / commit sequencer; digits only change in COMMIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= c_IDLE;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_ovf_pend <= 1'b0;
         r_digits   <= '0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (load) begin
                  r_bin      <= value;
                  r_bcd      <= '0;
                  r_cnt      <= '0;
                  r_ovf_pend <= (c_CMP_W'(value) > c_MAX);
                  r_state    <= c_SHIFT;
               end
            end
            c_SHIFT: begin
               r_bcd <= w_shifted[c_BCD_W+VALUE_W-1:VALUE_W];
               r_bin <= w_shifted[VALUE_W-1:0];
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_LAST) begin
                  r_state <= (SYNC_COMMIT != 0) ? c_WAIT : c_COMMIT;
               end
            end
            c_WAIT: begin
               if (frame_start) r_state <= c_COMMIT;
            end
            c_COMMIT: begin
               r_digits   <= r_ovf_pend ? {DIGITS{4'h9}} : r_bcd;
               r_overflow <= r_ovf_pend;
               r_state    <= c_IDLE;
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   // Glyph instances, MSD leftmost; blanking hides zero digits above the
   // highest nonzero one (ones digit always shown, nothing hidden on overflow).
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign w_nz[i] = |r_digits[4*i +: 4];
      if (i == 0 || BLANK_LZ == 0) begin : g_always
         assign w_show[i] = 1'b1;
      end else begin : g_blank
         assign w_show[i] = (|(w_nz >> i)) | r_overflow;
      end
      font16x32 #(
         .X0(x1 + 16 * (DIGITS - 1 - i)),
         .Y0(y1)
      ) u_font (
         .x       (x),
         .y       (y),
         .code    (r_digits[4*i +: 4]),
         .on_char (w_on_char[i])
      );
   end

   // Registered pixel flag; one clock of latency from x/y.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_on <= 1'b0;
      else       r_on <= |(w_on_char & w_show);
   end

   assign busy       = (r_state != c_IDLE);
   assign overflow   = r_overflow;
   assign on_display = r_on;

endmodule
`default_nettype wire

// File: doc/value_display.md
# value_display

Parametrised numeric readout for the VGA overlay, successor to the fixed two-digit humidity readout. It accepts a binary value and converts it to BCD with a sequential shift-and-add-3 (double-dabble) engine. Optionally it holds the result until a frame boundary so the displayed digits never tear mid-frame. It then renders N right-aligned 16x32 glyphs, with leading-zero blanking, through `font16x32` instances, producing a registered per-pixel "on" flag for the pixel mux.

## Interface
- `DIGITS`, 3: number of decimal digits rendered (1–6).
- `VALUE_W`, 10: width of binary input value.
- `x1`, 0: left pixel column of the most-significant digit.
- `y1`, 0: top pixel row of all digits.
- `BLANK_LZ`, 1: 1 = suppress leading zeros; 0 = show all digits.
- `SYNC_COMMIT`, 1: 1 = commit new digits only on `frame_start`; 0 = commit immediately after conversion.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `value`  in  VALUE_W  binary value to display, sampled on accepted `load`.
- `load`  in  1  single-cycle request to convert and display `value`.
- `frame_start`  in  1  one-cycle pulse at start of vertical blanking.
- `x`  in  10  current pixel column.
- `y`  in  10  current pixel row.
- `busy`  out  1  high while a conversion or commit is pending.
- `overflow`  out  1  displayed value was saturated.
- `on_display`  out  1  registered: current pixel lies on a lit glyph pixel.

## Operation
- FSM states: IDLE, SHIFT, WAIT_FRAME, COMMIT. `busy` = (state != IDLE).
- IDLE with `load`=1:
  - Capture `value` into the shift register.
  - Clear the BCD accumulator (4*DIGITS bits) and the bit counter.
  - Latch `ovf_pend` = (`value` > 10^DIGITS − 1).
  - Go to SHIFT.
- SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. After exactly VALUE_W cycles, go to WAIT_FRAME if `SYNC_COMMIT`, else COMMIT.
- WAIT_FRAME: stay until `frame_start`=1, then go to COMMIT. A `frame_start` seen in any other state is ignored.
- COMMIT (1 cycle):
  - Display digit registers ← BCD result, or all 9s if `ovf_pend`.
  - `overflow` ← `ovf_pend`.
  - Go to IDLE.
- `load` while `busy`=1 is dropped: no queueing, and the in-flight conversion is unaffected.
- Digit placement:
  - Digit i (i=0 is ones) renders at x = `x1` + 16*(DIGITS−1−i), y = `y1`.
  - One `font16x32` per digit, character code = that digit's display register.
- Blanking (`BLANK_LZ`=1): digit i>0 is masked off when it and all higher digits are 0. The ones digit is never blanked. With `overflow`=1 nothing is blanked.
- `on_display` ← OR over unmasked digits of `on_char`, registered once.
- Arithmetic: VALUE_W ≥ 1. BCD nibbles never exceed 9 after a correct add-3 step. When `ovf_pend` is set the result is discarded, so truncation of high BCD bits is harmless.

## Timing
- Reset (async, any state):
  - State → IDLE; `busy`=0; `overflow`=0.
  - All display digits = 0, so the display shows "0" with blanking on.
  - `on_display`=0.
  - A conversion in progress is abandoned; nothing is committed.
- `load` accepted at edge k:
  - `busy`=1 from k.
  - SHIFT occupies edges k+1 … k+VALUE_W.
- `SYNC_COMMIT`=0:
  - COMMIT at edge k+VALUE_W+1, where digits and `overflow` update.
  - `busy`=0 after that edge, so total occupancy is VALUE_W+1 cycles.
  - A new `load` may be accepted in the very next cycle.
- `SYNC_COMMIT`=1: COMMIT happens on the edge after the first `frame_start` sampled in WAIT_FRAME. Digits therefore change only during vertical blank.
- `on_display` latency: 1 clk from `x`/`y`. The pixel pipeline must delay colour by one cycle to match.
- `on_display` reflects digit registers as of the previous edge. A commit edge affects pixels sampled on the following cycle.

## Test plan
- Reset mid-SHIFT (VALUE_W=10): `load` of 742, assert `reset` after 4 cycles → `busy`=0 and `overflow`=0 immediately, digits stay 0, only the ones glyph lights.
- `SYNC_COMMIT`=0, `load` value=742 → `busy` high exactly 11 cycles; digits 7,4,2 then render at `x1`, `x1`+16, `x1`+32.
- Leading-zero blanking: value=5 → hundreds and tens masked, no lit pixel in x∈[`x1`, `x1`+32); value=0 → ones digit "0" lit; with `BLANK_LZ`=0 → "005".
- Overflow: value=1000 with DIGITS=3 → display 999 and `overflow`=1. A following `load` of 12 → `overflow`=0 and " 12" shown.
- `SYNC_COMMIT`=1: `load` 321, hold off `frame_start` 50 cycles → `busy` stays 1 and old digits stay shown; pulse `frame_start` → commit one edge later, `busy`=0. A `frame_start` during SHIFT is ignored.
- `load` while busy: second `load` with 99, 3 cycles into the first conversion (500) → 500 displayed, 99 never appears, no extra `busy` time.
